// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared encodings for the ARM single-cycle control unit.
//   - instruction opcode classes (Instr[27:26])
//   - condition-code enum (Instr[31:28])
//   - data-processing command field values (Funct[4:1])
//   - ALUControl and ImmSrc encodings driven to the datapath
//   - cond_eval(): condition-code evaluation against {N,Z,C,V}
package arm_ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Returns 1 when the condition passes for flags {N,Z,C,V}.
  function automatic logic cond_eval(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic r;
    r = 1'b0;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      COND_NV: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm_cond_logic.sv
// arm_cond_logic: NZCV flag registers, condition evaluation and write gating.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   cond[3:0]        condition field of the current instruction
//   alu_flags[3:0]   {N,Z,C,V} from the ALU, same cycle
//   flag_w[1:0]      [1] writes N,Z; [0] writes C,V
//   pcs, reg_w, mem_w  ungated write requests from decode
//   pc_src, reg_write, mem_write  condition- and reset-gated writes
//   flags[3:0]       registered {N,Z,C,V}
//   cond_ex          condition passes against the registered flags
module arm_cond_logic
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags,
  output logic       cond_ex
);

  logic [3:0] flags_q;

  // Evaluated on the registered flags only; same-cycle ALU flags never feed back.
  assign cond_ex = cond_eval(cond_e'(cond), flags_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RESET;
    end else if (cond_ex) begin
      if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
      if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
    end
  end

  assign flags     = flags_q;
  assign reg_write = reg_w & cond_ex & ~reset;
  assign mem_write = mem_w & cond_ex & ~reset;
  assign pc_src    = pcs   & cond_ex & ~reset;

endmodule

// File: rtl/arm_control_unit.sv
// arm_control_unit: single-cycle ARM control unit (decode + condition gating).
// Optional feature macro: ARM_CTRL_PERF_EN (retired/squashed counters).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   Instr[31:0]       current instruction
//   ALUFlags[3:0]     {N,Z,C,V} from the ALU
//   RegSrc, ImmSrc, ALUSrc, ALUControl, MemtoReg   datapath selects
//   RegWrite, MemWrite, PCSrc   condition-gated architectural writes
//   Flags[3:0]        registered {N,Z,C,V}
//   perf_retired, perf_squashed   executed / condition-failed counts (0 when disabled)
module arm_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [1:0]  ALUControl,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        PCSrc,
  output logic [3:0]  Flags,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_squashed
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       reg_w, mem_w, branch, alu_op, pcs, cond_ex;
  logic [1:0] flag_w;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];

  always_comb begin
    RegSrc     = 2'b00;
    ImmSrc     = IMM_DP;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;

    case (op)
      OP_DP: begin
        ALUSrc = funct[5];
        reg_w  = 1'b1;
        alu_op = 1'b1;
      end
      OP_MEM: begin
        ImmSrc = IMM_MEM;
        ALUSrc = 1'b1;
        if (funct[0]) begin
          MemtoReg = 1'b1;
          reg_w    = 1'b1;
        end else begin
          RegSrc = 2'b10;
          mem_w  = 1'b1;
        end
      end
      OP_BR: begin
        RegSrc = 2'b01;
        ImmSrc = IMM_BR;
        ALUSrc = 1'b1;
        branch = 1'b1;
      end
      default: ;
    endcase

    // Unsupported data-processing commands suppress the register write
    // here so that PCS below also sees the suppressed write.
    if (alu_op) begin
      case (cmd)
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: reg_w = 1'b0;
      endcase
      if ((cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) || (cmd == CMD_ORR)) begin
        flag_w[1] = funct[0];
        flag_w[0] = funct[0] & ((cmd == CMD_ADD) || (cmd == CMD_SUB));
      end
    end
  end

  assign pcs = ((rd == 4'hF) & reg_w) | branch;

  arm_cond_logic #(
    .FLAG_RESET (FLAG_RESET)
  ) u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Instr[31:28]),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .pc_src    (PCSrc),
    .reg_write (RegWrite),
    .mem_write (MemWrite),
    .flags     (Flags),
    .cond_ex   (cond_ex)
  );

`ifdef ARM_CTRL_PERF_EN
  logic [31:0] retired_q, squashed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q  <= '0;
      squashed_q <= '0;
    end else if (cond_ex) begin
      retired_q  <= retired_q + 32'd1;
    end else begin
      squashed_q <= squashed_q + 32'd1;
    end
  end

  assign perf_retired  = retired_q;
  assign perf_squashed = squashed_q;

  logic unused_bits;
  assign unused_bits = ^{Instr[19:16], Instr[11:0]};
`else
  assign perf_retired  = '0;
  assign perf_squashed = '0;

  logic unused_bits;
  assign unused_bits = ^{Instr[19:16], Instr[11:0], cond_ex};
`endif

endmodule

// File: tb/tb_arm_control_unit.sv
// Scoreboard bench for arm_control_unit: the stimulus process pushes the
// hand-computed response of every applied vector; a monitor on the falling
// edge pops and compares control word, flags and performance counters.
module tb_arm_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemtoReg;
  logic        MemWrite;
  logic        PCSrc;
  logic [3:0]  Flags;
  logic [31:0] perf_retired;
  logic [31:0] perf_squashed;

  arm_control_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .Instr         (Instr),
    .ALUFlags      (ALUFlags),
    .RegSrc        (RegSrc),
    .RegWrite      (RegWrite),
    .ImmSrc        (ImmSrc),
    .ALUSrc        (ALUSrc),
    .ALUControl    (ALUControl),
    .MemtoReg      (MemtoReg),
    .MemWrite      (MemWrite),
    .PCSrc         (PCSrc),
    .Flags         (Flags),
    .perf_retired  (perf_retired),
    .perf_squashed (perf_squashed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] ctrl;
    logic [3:0]  flags;
    logic [31:0] ret;
    logic [31:0] sq;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] model_ret = '0;
  logic [31:0] model_sq = '0;

  // {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, MemWrite, PCSrc}
  task automatic vec(input string nm, input logic rst, input logic [31:0] ins,
                     input logic [3:0] af, input logic [1:0] rs, input logic rw,
                     input logic [1:0] is, input logic as, input logic [1:0] ac,
                     input logic mr, input logic mw, input logic pc,
                     input logic [3:0] fl, input logic cx);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    Instr    = ins;
    ALUFlags = af;
    e.name  = nm;
    e.ctrl  = {rs, rw, is, as, ac, mr, mw, pc};
    e.flags = fl;
    e.ret   = model_ret;
    e.sq    = model_sq;
    sb.push_back(e);
    if (rst) begin
      model_ret = '0;
      model_sq  = '0;
    end else if (cx) begin
      model_ret = model_ret + 32'd1;
    end else begin
      model_sq = model_sq + 32'd1;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [10:0] act;
      e   = sb.pop_front();
      act = {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, MemWrite, PCSrc};
      compared++;
      if (act !== e.ctrl) begin
        mismatched++;
        $display("FAIL %s ctrl: got %b, expected %b", e.name, act, e.ctrl);
      end
      compared++;
      if (Flags !== e.flags) begin
        mismatched++;
        $display("FAIL %s flags: got %b, expected %b", e.name, Flags, e.flags);
      end
`ifdef ARM_CTRL_PERF_EN
      compared++;
      if ((perf_retired !== e.ret) || (perf_squashed !== e.sq)) begin
        mismatched++;
        $display("FAIL %s perf: got %0d/%0d, expected %0d/%0d",
                 e.name, perf_retired, perf_squashed, e.ret, e.sq);
      end
`else
      compared++;
      if ((perf_retired !== 32'd0) || (perf_squashed !== 32'd0)) begin
        mismatched++;
        $display("FAIL %s perf_tied: got %h/%h, expected 0/0",
                 e.name, perf_retired, perf_squashed);
      end
`endif
    end
  end

  initial begin
    reset    = 1'b1;
    Instr    = 32'h0;
    ALUFlags = 4'h0;
    repeat (2) @(posedge clk);
    //   name              rst instr         af       rs     rw    is     as    ac     mr    mw    pc    flags    cx
    vec("reset_state",     1, 32'hE0921003, 4'b1111, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("adds",            0, 32'hE0921003, 4'b0100, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("beq_taken",       0, 32'h0A000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1);
    vec("adds_clear",      0, 32'hE0921003, 4'b0000, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
    vec("beq_not_taken",   0, 32'h0A000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    vec("str",             0, 32'hE5854008, 4'b1111, 2'b10, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
    vec("orr_nos",         0, 32'hE1821003, 4'b1111, 2'b00, 1'b1, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("ldr",             0, 32'hE5954008, 4'b1111, 2'b00, 1'b1, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("add_pc",          0, 32'hE082F003, 4'b0000, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    vec("add_pc_nv",       0, 32'hF082F003, 4'b0000, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    vec("undef_cmd",       0, 32'hE0321003, 4'b1111, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("ands",            0, 32'hE0121003, 4'b1111, 2'b00, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("subs",            0, 32'hE0521003, 4'b1111, 2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b1);
    vec("bne_z_set",       0, 32'h1A000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    vec("reset_subs",      1, 32'hE0521003, 4'b1010, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    vec("beq_after_reset", 0, 32'h0A000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    vec("bge",             0, 32'hAA000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    vec("bhi",             0, 32'h8A000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    vec("op11",            0, 32'hEC000000, 4'b1111, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("ands_neg",        0, 32'hE0121003, 4'b1000, 2'b00, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    vec("blt",             0, 32'hBA000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1);
    vec("bgt",             0, 32'hCA000002, 4'b0000, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);

    for (int i = 0; i < 4; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
